// File: rtl/sdram_arb_if.sv
// Bus bundle between sdram_arb, its two clients and the sdrc_core application port.
// master = arbiter side, slave = clients plus core.
interface sdram_arb_if #(
    parameter int AW = 26,
    parameter int LW = 9,
    parameter int DW = 32
);
    logic                sdr_init_done;
    logic [1:0]          c_req;
    logic [2*AW-1:0]     c_addr;
    logic [2*LW-1:0]     c_len;
    logic [1:0]          c_wr_n;
    logic [1:0]          c_ack;
    logic [2*DW-1:0]     c_wr_data;
    logic [2*(DW/8)-1:0] c_wr_en_n;
    logic [1:0]          c_wr_next;
    logic [DW-1:0]       c_rd_data;
    logic [1:0]          c_rd_valid;
    logic                app_req;
    logic                app_req_dma_last;
    logic [AW-1:0]       app_req_addr;
    logic [LW-1:0]       app_req_len;
    logic                app_req_wr_n;
    logic                app_req_ack;
    logic [DW-1:0]       app_wr_data;
    logic [DW/8-1:0]     app_wr_en_n;
    logic                app_wr_next_req;
    logic                app_last_wr;
    logic [DW-1:0]       app_rd_data;
    logic                app_rd_valid;
    logic                app_last_rd;
    logic                busy;
    logic                grant;
    logic                timeout_err;

    modport master (
        input  sdr_init_done, c_req, c_addr, c_len, c_wr_n, c_wr_data, c_wr_en_n,
        input  app_req_ack, app_wr_next_req, app_last_wr, app_rd_data, app_rd_valid, app_last_rd,
        output c_ack, c_wr_next, c_rd_data, c_rd_valid,
        output app_req, app_req_dma_last, app_req_addr, app_req_len, app_req_wr_n,
        output app_wr_data, app_wr_en_n, busy, grant, timeout_err
    );

    modport slave (
        output sdr_init_done, c_req, c_addr, c_len, c_wr_n, c_wr_data, c_wr_en_n,
        output app_req_ack, app_wr_next_req, app_last_wr, app_rd_data, app_rd_valid, app_last_rd,
        input  c_ack, c_wr_next, c_rd_data, c_rd_valid,
        input  app_req, app_req_dma_last, app_req_addr, app_req_len, app_req_wr_n,
        input  app_wr_data, app_wr_en_n, busy, grant, timeout_err
    );
endinterface

// File: rtl/sdram_arb.sv
// Round-robin two-client arbiter/sequencer for the sdrc_core application port,
// one transaction outstanding at a time, with a data-phase watchdog.
module sdram_arb #(
    parameter int AW      = 26,
    parameter int LW      = 9,
    parameter int DW      = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic         sdram_clk,
    input  logic         rst_n,
    sdram_arb_if.master  bus
);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WR, RD} state_t;

    state_t         state;
    logic           grant;
    logic           last_grant;
    logic [WDW-1:0] wd;
    logic           timeout_err;

    logic           req_live;
    logic [LW-1:0]  g_len;
    logic           len_zero;
    logic           g_wr_n;
    logic           strobe;
    logic           last;
    logic [1:0]     ack;
    logic [1:0]     wr_next;
    logic [1:0]     rd_valid;
    logic           req;

    assign req_live = bus.c_req[grant];
    assign g_len    = grant ? bus.c_len[2*LW-1:LW] : bus.c_len[LW-1:0];
    assign g_wr_n   = bus.c_wr_n[grant];
    assign len_zero = (g_len == '0);
    assign strobe   = bus.app_wr_next_req | bus.app_rd_valid;
    assign last     = (state == WR) ? bus.app_last_wr : bus.app_last_rd;

    // Handshake and data strobes are combinational so the core sees no extra latency.
    always_comb begin
        req      = (state == REQ) && req_live && !len_zero;
        ack      = '0;
        wr_next  = '0;
        rd_valid = '0;
        if (state == REQ && req_live && (len_zero || bus.app_req_ack))
            ack[grant] = 1'b1;
        if (state == WR)
            wr_next[grant] = bus.app_wr_next_req;
        if (state == RD)
            rd_valid[grant] = bus.app_rd_valid;
    end

    assign bus.app_req          = req;
    assign bus.app_req_dma_last = req;
    assign bus.app_req_addr     = grant ? bus.c_addr[2*AW-1:AW] : bus.c_addr[AW-1:0];
    assign bus.app_req_len      = g_len;
    assign bus.app_req_wr_n     = g_wr_n;
    assign bus.app_wr_data      = grant ? bus.c_wr_data[2*DW-1:DW] : bus.c_wr_data[DW-1:0];
    assign bus.app_wr_en_n      = grant ? bus.c_wr_en_n[2*(DW/8)-1:DW/8] : bus.c_wr_en_n[DW/8-1:0];
    assign bus.c_ack            = ack;
    assign bus.c_wr_next        = wr_next;
    assign bus.c_rd_valid       = rd_valid;
    assign bus.c_rd_data        = bus.app_rd_data;
    assign bus.busy             = (state != IDLE);
    assign bus.grant            = grant;
    assign bus.timeout_err      = timeout_err;

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            wd          <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.sdr_init_done && (bus.c_req != 2'b00)) begin
                        grant <= (bus.c_req == 2'b11) ? ~last_grant : bus.c_req[1];
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (!req_live) begin
                        state <= IDLE;
                    end else if (len_zero) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end else if (bus.app_req_ack) begin
                        state <= g_wr_n ? RD : WR;
                        wd    <= '0;
                    end
                end
                WR, RD: begin
                    // A data strobe coinciding with last is still forwarded combinationally.
                    if (last) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end else if (strobe) begin
                        wd <= '0;
                    end else if (wd == WDW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        last_grant  <= grant;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: init gating, round-robin, data routing,
// zero-length requests, watchdog abort and asynchronous reset.
module tb_sdram_arb;
    localparam int AW = 26;
    localparam int LW = 9;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam logic [AW-1:0] ADDR0 = 26'h0000100;
    localparam logic [AW-1:0] ADDR1 = 26'h0002000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sdram_arb_if #(.AW(AW), .LW(LW), .DW(DW)) bus ();

    sdram_arb #(.AW(AW), .LW(LW), .DW(DW), .TIMEOUT(TO)) dut (
        .sdram_clk (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_len(input int l0, input int l1);
        bus.c_len = {LW'(l1), LW'(l0)};
    endtask

    task automatic clear_core();
        bus.app_req_ack     = 1'b0;
        bus.app_wr_next_req = 1'b0;
        bus.app_last_wr     = 1'b0;
        bus.app_rd_valid    = 1'b0;
        bus.app_last_rd     = 1'b0;
    endtask

    // Called from an IDLE cycle (after its falling edge); runs REQ plus n data beats.
    task automatic run_txn(input int g, input int n, input bit wr);
        logic [1:0] m;
        m = (g == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        clear_core();
        #1;
        check("req_grant", bus.grant, 64'(g));
        check("req_app_req", bus.app_req, 1);
        check("req_dma_last", bus.app_req_dma_last, 1);
        check("req_no_ack", bus.c_ack, 0);
        check("req_addr", bus.app_req_addr, (g == 1) ? ADDR1 : ADDR0);
        check("req_len", bus.app_req_len, 64'(n));
        check("req_wr_n", bus.app_req_wr_n, wr ? 0 : 1);
        bus.app_req_ack = 1'b1;
        #1;
        check("req_ack", bus.c_ack, m);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_core();
            if (wr) begin
                bus.app_wr_next_req = 1'b1;
                bus.app_last_wr     = (i == n - 1);
                bus.c_wr_data = (g == 1) ? {DW'(10 + i), 32'hDEADBEEF} : {32'hDEADBEEF, DW'(10 + i)};
                #1;
                check("wr_next", bus.c_wr_next, m);
                check("wr_no_rvalid", bus.c_rd_valid, 0);
                check("wr_data", bus.app_wr_data, 64'(10 + i));
                check("wr_en_n", bus.app_wr_en_n, (g == 1) ? 4'h3 : 4'h0);
            end else begin
                bus.app_rd_valid = 1'b1;
                bus.app_last_rd  = (i == n - 1);
                bus.app_rd_data  = 32'hA000_0000 + i;
                #1;
                check("rd_valid", bus.c_rd_valid, m);
                check("rd_no_wnext", bus.c_wr_next, 0);
                check("rd_data", bus.c_rd_data, 64'(32'hA000_0000 + i));
            end
        end
        @(negedge clk);
        clear_core();
        // Core strobes and a stray ack in IDLE must not reach any client.
        bus.app_wr_next_req = 1'b1;
        bus.app_rd_valid    = 1'b1;
        bus.app_req_ack     = 1'b1;
        #1;
        check("idle_busy", bus.busy, 0);
        check("idle_wnext", bus.c_wr_next, 0);
        check("idle_rvalid", bus.c_rd_valid, 0);
        check("idle_ack", bus.c_ack, 0);
    endtask

    initial begin
        int bad;
        int cnt;
        rst_n              = 1'b0;
        bus.sdr_init_done  = 1'b0;
        bus.c_req          = 2'b00;
        bus.c_addr         = {ADDR1, ADDR0};
        bus.c_wr_n         = 2'b10;
        bus.c_wr_data      = '0;
        bus.c_wr_en_n      = {4'h3, 4'h0};
        bus.app_rd_data    = '0;
        set_len(4, 8);
        clear_core();

        repeat (2) @(negedge clk);
        #1;
        check("rst_app_req", bus.app_req, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_terr", bus.timeout_err, 0);
        check("rst_ack", bus.c_ack, 0);
        check("rst_wnext", bus.c_wr_next, 0);
        check("rst_rvalid", bus.c_rd_valid, 0);

        // No arbitration until init completes.
        @(negedge clk);
        rst_n     = 1'b1;
        bus.c_req = 2'b11;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (bus.app_req || (bus.c_ack != 2'b00) || bus.busy) bad++;
        end
        check("noinit_quiet", 64'(bad), 0);
        bus.sdr_init_done = 1'b1;

        // Continuous requests from both: grants alternate 0,1,0,1.
        run_txn(0, 4, 1'b1);
        run_txn(1, 8, 1'b0);
        run_txn(0, 4, 1'b1);
        run_txn(1, 8, 1'b0);

        // Single writer, len 5, data 10..14.
        bus.c_req = 2'b01;
        set_len(5, 8);
        run_txn(0, 5, 1'b1);

        // Zero-length request on client 1: ack only, no app_req.
        bus.c_req = 2'b10;
        set_len(5, 0);
        @(negedge clk);
        clear_core();
        bus.c_req = 2'b11;
        #1;
        check("zl_grant", bus.grant, 1);
        check("zl_app_req", bus.app_req, 0);
        check("zl_ack", bus.c_ack, 2'b10);
        @(negedge clk);
        set_len(5, 8);
        #1;
        check("zl_idle", bus.busy, 0);
        check("zl_ack_gone", bus.c_ack, 0);
        run_txn(0, 5, 1'b1);

        // Watchdog: client 1 read stalls after 2 of 8 beats.
        @(negedge clk);
        clear_core();
        #1;
        check("to_grant", bus.grant, 1);
        bus.app_req_ack = 1'b1;
        #1;
        check("to_ack", bus.c_ack, 2'b10);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            clear_core();
            bus.app_rd_valid = 1'b1;
            #1;
            check("to_rvalid", bus.c_rd_valid, 2'b10);
        end
        @(negedge clk);
        clear_core();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!bus.busy) break;
            cnt++;
            @(negedge clk);
        end
        check("to_cycles", 64'(cnt), 16);
        check("to_terr", bus.timeout_err, 1);
        run_txn(0, 5, 1'b1);
        check("to_sticky", bus.timeout_err, 1);

        // Asynchronous reset in the middle of a write.
        bus.c_req = 2'b01;
        @(negedge clk);
        clear_core();
        bus.app_req_ack = 1'b1;
        @(negedge clk);
        clear_core();
        bus.app_wr_next_req = 1'b1;
        bus.c_wr_data = {32'hDEADBEEF, 32'd10};
        @(negedge clk);
        clear_core();
        #1;
        check("mid_wr_busy", bus.busy, 1);
        #1;
        rst_n = 1'b0;
        bus.app_wr_next_req = 1'b1;
        bus.app_rd_valid    = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_wnext", bus.c_wr_next, 0);
        check("arst_rvalid", bus.c_rd_valid, 0);
        check("arst_terr", bus.timeout_err, 0);
        check("arst_app_req", bus.app_req, 0);
        check("arst_grant", bus.grant, 0);
        bus.c_req = 2'b11;
        repeat (2) @(negedge clk);
        clear_core();
        rst_n = 1'b1;
        run_txn(0, 5, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
